button_conditioner: RTL and testbench

Input conditioning stage for the traffic/colour light controller. It synchronises the raw push-button, debounces it, and produces the single-cycle `button` advance pulse consumed by the `lights` stage, whose colour register advances on every cycle `button` is high. Holding the button produces auto-repeat pulses at a fixed rate. One pulse on `button` advances the colour exactly one step.

---
 rtl/button_conditioner.sv | 133 +++++++++++++
 tb/tb_button_conditioner.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Push-button input conditioning: two-flop synchroniser, debounce,
// and single-cycle advance pulses with optional hold-to-repeat.
module button_conditioner #(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int AUTO_REPEAT     = 1,
   parameter int REPEAT_DELAY    = 64,
   parameter int REPEAT_PERIOD   = 32
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic button,
   output logic pressed,
   output logic repeating
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                         REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RW = $clog2(RMAX + 1);

   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } state_t;

   state_t state;

   logic s1;
   logic s2;
   logic [DW-1:0] db_cnt;
   logic [RW-1:0] rpt_cnt;

   logic db_diff;
   logic db_done;
   logic rise;
   logic fall;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn_in;
         s2 <= s1;
      end
   end

   // rise/fall flag the edge on which pressed is about to change,
   // so the FSM reacts on that same edge
   always_comb begin
      db_diff = s2 != pressed;
      db_done = db_diff && (db_cnt == DB_LAST);
      rise    = db_done && s2;
      fall    = db_done && !s2;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pressed <= 1'b0;
         db_cnt  <= '0;
      end else if (db_diff) begin
         if (db_done) begin
            pressed <= s2;
            db_cnt  <= '0;
         end else begin
            db_cnt <= db_cnt + DW'(1);
         end
      end else begin
         db_cnt <= '0;
      end
   end

   // A release on the same edge as a due repeat pulse suppresses it
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         rpt_cnt   <= '0;
         button    <= 1'b0;
         repeating <= 1'b0;
      end else begin
         button <= 1'b0;
         unique case (state)
            IDLE: begin
               rpt_cnt   <= '0;
               repeating <= 1'b0;
               if (rise) begin
                  button <= 1'b1;
                  state  <= DELAY;
               end
            end
            DELAY: begin
               if (fall) begin
                  state   <= IDLE;
                  rpt_cnt <= '0;
               end else if (AUTO_REPEAT != 0) begin
                  if (rpt_cnt == DLY_LAST) begin
                     button    <= 1'b1;
                     rpt_cnt   <= '0;
                     state     <= REPEAT;
                     repeating <= 1'b1;
                  end else begin
                     rpt_cnt <= rpt_cnt + RW'(1);
                  end
               end
            end
            REPEAT: begin
               if (fall) begin
                  state     <= IDLE;
                  rpt_cnt   <= '0;
                  repeating <= 1'b0;
               end else if (rpt_cnt == PER_LAST) begin
                  button  <= 1'b1;
                  rpt_cnt <= '0;
               end else begin
                  rpt_cnt <= rpt_cnt + RW'(1);
               end
            end
            default: begin
               state     <= IDLE;
               rpt_cnt   <= '0;
               repeating <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulse edges are
// queued by the stimulus and consumed by a monitor on each pulse.
module tb_button_conditioner;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_in = 1'b0;

   logic button, pressed, repeating;
   logic nr_button, nr_pressed, nr_repeating;

   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int q_ar[$];
   int q_nr[$];
   logic [2:0] colour;

   int colour_exp[7] = '{1, 2, 3, 4, 5, 6, 1};

   button_conditioner dut (
      .clk(clk),
      .rst(rst),
      .btn_in(btn_in),
      .button(button),
      .pressed(pressed),
      .repeating(repeating)
   );

   button_conditioner #(.AUTO_REPEAT(0)) dut_nr (
      .clk(clk),
      .rst(rst),
      .btn_in(btn_in),
      .button(nr_button),
      .pressed(nr_pressed),
      .repeating(nr_repeating)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the lights colour register
   always @(posedge clk) begin
      if (rst) colour <= 3'd0;
      else if (button) colour <= (colour == 3'd6) ? 3'd1 : colour + 3'd1;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0h expected %0h",
                  name, cyc, act, exp);
      end
   endtask

   task automatic wait_until(input int e);
      if (cyc > e) begin
         checks++;
         errors++;
         $display("FAIL sequencing: at edge %0d, wanted edge %0d", cyc, e);
      end
      while (cyc < e) @(negedge clk);
   endtask

   task automatic set_btn(input int e, input logic v);
      wait_until(e - 1);
      btn_in = v;
   endtask

   task automatic push_both(input int e);
      q_ar.push_back(e);
      q_nr.push_back(e);
   endtask

   initial begin
      fork
         forever begin
            @(negedge clk);
            while (q_ar.size() > 0 && q_ar[0] < cyc) begin
               checks++;
               errors++;
               $display("FAIL ar_pulse: missing, expected edge %0d",
                        q_ar.pop_front());
            end
            while (q_nr.size() > 0 && q_nr[0] < cyc) begin
               checks++;
               errors++;
               $display("FAIL nr_pulse: missing, expected edge %0d",
                        q_nr.pop_front());
            end
            if (button === 1'b1) begin
               checks++;
               if (q_ar.size() == 0) begin
                  errors++;
                  $display("FAIL ar_pulse: got edge %0d expected none", cyc);
               end else if (q_ar[0] != cyc) begin
                  errors++;
                  $display("FAIL ar_pulse: got edge %0d expected edge %0d",
                           cyc, q_ar[0]);
               end else begin
                  void'(q_ar.pop_front());
               end
            end
            if (nr_button === 1'b1) begin
               checks++;
               if (q_nr.size() == 0) begin
                  errors++;
                  $display("FAIL nr_pulse: got edge %0d expected none", cyc);
               end else if (q_nr[0] != cyc) begin
                  errors++;
                  $display("FAIL nr_pulse: got edge %0d expected edge %0d",
                           cyc, q_nr[0]);
               end else begin
                  void'(q_nr.pop_front());
               end
            end
         end
         begin
            int e0;
            rst = 1'b1;
            btn_in = 1'b0;
            repeat (3) @(negedge clk);
            check("reset_button", 32'(button), 0);
            check("reset_pressed", 32'(pressed), 0);
            check("reset_repeating", 32'(repeating), 0);
            check("reset_nr_button", 32'(nr_button), 0);
            check("reset_nr_pressed", 32'(nr_pressed), 0);
            rst = 1'b0;

            // clean press and release
            e0 = cyc + 3;
            push_both(e0 + 17);
            set_btn(e0, 1'b1);
            wait_until(e0 + 16);
            check("clean_pressed_16", 32'(pressed), 0);
            wait_until(e0 + 17);
            check("clean_pressed_17", 32'(pressed), 1);
            set_btn(e0 + 40, 1'b0);
            wait_until(e0 + 56);
            check("clean_pressed_56", 32'(pressed), 1);
            check("clean_repeating", 32'(repeating), 0);
            wait_until(e0 + 57);
            check("clean_pressed_57", 32'(pressed), 0);
            wait_until(e0 + 80);

            // bounce: toggles every 3 cycles, last rise at +30
            e0 = cyc + 3;
            push_both(e0 + 47);
            for (int i = 0; i < 10; i++)
               set_btn(e0 + 3 * i, (i % 2 == 0) ? 1'b1 : 1'b0);
            set_btn(e0 + 30, 1'b1);
            wait_until(e0 + 46);
            check("bounce_pressed_46", 32'(pressed), 0);
            wait_until(e0 + 47);
            check("bounce_pressed_47", 32'(pressed), 1);
            set_btn(e0 + 70, 1'b0);
            wait_until(e0 + 100);

            // auto-repeat hold, release lands pressed fall at +207
            e0 = cyc + 3;
            q_ar.push_back(e0 + 17);
            q_ar.push_back(e0 + 81);
            q_ar.push_back(e0 + 113);
            q_ar.push_back(e0 + 145);
            q_ar.push_back(e0 + 177);
            q_nr.push_back(e0 + 17);
            set_btn(e0, 1'b1);
            wait_until(e0 + 80);
            check("hold_repeating_80", 32'(repeating), 0);
            wait_until(e0 + 81);
            check("hold_repeating_81", 32'(repeating), 1);
            wait_until(e0 + 150);
            check("hold_nr_repeating", 32'(nr_repeating), 0);
            check("hold_nr_pressed", 32'(nr_pressed), 1);
            set_btn(e0 + 190, 1'b0);
            wait_until(e0 + 206);
            check("hold_repeating_206", 32'(repeating), 1);
            wait_until(e0 + 207);
            check("hold_repeating_207", 32'(repeating), 0);
            check("hold_pressed_207", 32'(pressed), 0);
            wait_until(e0 + 230);

            // release coincident with the repeat due at +113
            e0 = cyc + 3;
            q_ar.push_back(e0 + 17);
            q_ar.push_back(e0 + 81);
            q_nr.push_back(e0 + 17);
            set_btn(e0, 1'b1);
            set_btn(e0 + 96, 1'b0);
            wait_until(e0 + 112);
            check("coinc_repeating_112", 32'(repeating), 1);
            check("coinc_pressed_112", 32'(pressed), 1);
            wait_until(e0 + 113);
            check("coinc_repeating_113", 32'(repeating), 0);
            check("coinc_pressed_113", 32'(pressed), 0);
            wait_until(e0 + 140);

            // reset mid-hold at +90 with the button still down
            e0 = cyc + 3;
            q_ar.push_back(e0 + 17);
            q_ar.push_back(e0 + 81);
            q_ar.push_back(e0 + 108);
            q_nr.push_back(e0 + 17);
            q_nr.push_back(e0 + 108);
            set_btn(e0, 1'b1);
            wait_until(e0 + 89);
            rst = 1'b1;
            wait_until(e0 + 90);
            rst = 1'b0;
            check("rst_button", 32'(button), 0);
            check("rst_pressed", 32'(pressed), 0);
            check("rst_repeating", 32'(repeating), 0);
            check("rst_nr_pressed", 32'(nr_pressed), 0);
            wait_until(e0 + 107);
            check("rst_pressed_107", 32'(pressed), 0);
            wait_until(e0 + 108);
            check("rst_pressed_108", 32'(pressed), 1);
            set_btn(e0 + 120, 1'b0);
            wait_until(e0 + 160);

            // integration: seven presses step the colour register
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            check("lights_reset", 32'(colour), 0);
            for (int i = 0; i < 7; i++) begin
               e0 = cyc + 3;
               push_both(e0 + 17);
               set_btn(e0, 1'b1);
               wait_until(e0 + 18);
               check($sformatf("lights_press%0d", i), 32'(colour),
                     32'(colour_exp[i]));
               set_btn(e0 + 25, 1'b0);
               wait_until(e0 + 50);
            end

            repeat (5) @(negedge clk);
            while (q_ar.size() > 0) begin
               checks++;
               errors++;
               $display("FAIL ar_pulse: missing, expected edge %0d",
                        q_ar.pop_front());
            end
            while (q_nr.size() > 0) begin
               checks++;
               errors++;
               $display("FAIL nr_pulse: missing, expected edge %0d",
                        q_nr.pop_front());
            end
            $display("Simulation finished: %0d checks, %0d errors",
                     checks, errors);
            $finish;
         end
      join
   end

endmodule
